uart_cmd_wrapper: RTL and testbench

Device-side endpoint of the host command link in the logic-analyzer digital core. Deserializes UART bytes on `RX`, assembles each pair into a 16-bit command (high byte first) for the command processor, and serializes 8-bit responses (`8'hA5` ack, `8'hEE` nack, or read data) back to the host on `TX`. Sits between the board UART pins and the command/config register block, as the counterpart of the host-side command master.

---
 rtl/uart_cmd_wrapper_if.sv | 21 ++
 rtl/uart_cmd_wrapper.sv | 214 +++++++++++++++++++++
 tb/tb_uart_cmd_wrapper.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_wrapper_if.sv
// rtl/uart_cmd_wrapper_if.sv - command/response handshake bundle of the UART command endpoint
interface uart_cmd_wrapper_if;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic [7:0]  resp;
  logic        send_resp;
  logic        resp_sent;
  logic        tx_busy;
  logic        frame_err;

  modport slave (
    output cmd, cmd_rdy, resp_sent, tx_busy, frame_err,
    input  clr_cmd_rdy, resp, send_resp
  );

  modport master (
    input  cmd, cmd_rdy, resp_sent, tx_busy, frame_err,
    output clr_cmd_rdy, resp, send_resp
  );
endinterface

// File: rtl/uart_cmd_wrapper.sv
// rtl/uart_cmd_wrapper.sv - UART 8N1 endpoint: byte pairs in as 16-bit commands, 8-bit responses out
// Optional CMD_TIMEOUT_EN: drop a lone high byte after TIMEOUT_CYC idle clocks.
module uart_cmd_wrapper #(
  parameter int BAUD_DIV = 108
`ifdef CMD_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 20000
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 RX,
  output logic                 TX,
  uart_cmd_wrapper_if.slave    bus
);

  localparam int CW = $clog2(BAUD_DIV + 1);
  localparam logic [CW-1:0] FULL = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic {TX_IDLE, TX_BUSY} tx_state_t;

  rx_state_t   rx_state, rx_state_n;
  logic [CW-1:0] rx_cnt, rx_cnt_n;
  logic [2:0]  rx_idx, rx_idx_n;
  logic [7:0]  rx_shift, rx_shift_n;
  logic        rx_s1, rx_s2, rx_prev;
  logic        rx_fall, byte_ok, bad_stop, start_ok, timeout;

  logic        asm_low;
  logic [7:0]  cmd_hi;
  logic [15:0] cmd_q;
  logic        cmd_rdy_q, frame_err_q;

  tx_state_t   tx_state, tx_state_n;
  logic [CW-1:0] tx_cnt, tx_cnt_n;
  logic [3:0]  tx_idx, tx_idx_n;
  logic [9:0]  tx_shift, tx_shift_n;
  logic        tx_done, resp_sent_q;

  assign rx_fall = rx_prev & ~rx_s2;

  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_idx_n   = rx_idx;
    rx_shift_n = rx_shift;
    byte_ok    = 1'b0;
    bad_stop   = 1'b0;
    start_ok   = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (rx_fall) begin
          rx_state_n = RX_START;
          rx_cnt_n   = HALF;
        end
      end
      RX_START: begin
        if (rx_cnt == '0) begin
          if (!rx_s2) begin
            rx_state_n = RX_DATA;
            rx_cnt_n   = FULL;
            rx_idx_n   = 3'd0;
            start_ok   = 1'b1;
          end else begin
            rx_state_n = RX_IDLE;
          end
        end else begin
          rx_cnt_n = rx_cnt - CW'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt == '0) begin
          rx_shift_n = {rx_s2, rx_shift[7:1]};
          rx_cnt_n   = FULL;
          if (rx_idx == 3'd7) rx_state_n = RX_STOP;
          else                rx_idx_n   = rx_idx + 3'd1;
        end else begin
          rx_cnt_n = rx_cnt - CW'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt == '0) begin
          rx_state_n = RX_IDLE;
          byte_ok    = rx_s2;
          bad_stop   = ~rx_s2;
        end else begin
          rx_cnt_n = rx_cnt - CW'(1);
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1       <= 1'b1;
      rx_s2       <= 1'b1;
      rx_prev     <= 1'b1;
      rx_state    <= RX_IDLE;
      rx_cnt      <= '0;
      rx_idx      <= 3'd0;
      rx_shift    <= 8'h00;
      asm_low     <= 1'b0;
      cmd_hi      <= 8'h00;
      cmd_q       <= 16'h0000;
      cmd_rdy_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_s1       <= RX;
      rx_s2       <= rx_s1;
      rx_prev     <= rx_s2;
      rx_state    <= rx_state_n;
      rx_cnt      <= rx_cnt_n;
      rx_idx      <= rx_idx_n;
      rx_shift    <= rx_shift_n;
      frame_err_q <= bad_stop;
      if (bad_stop || timeout) begin
        asm_low <= 1'b0;
      end else if (byte_ok) begin
        if (!asm_low) begin
          cmd_hi  <= rx_shift;
          asm_low <= 1'b1;
        end else begin
          cmd_q   <= {cmd_hi, rx_shift};
          asm_low <= 1'b0;
        end
      end
      // completion beats a simultaneous clear
      if (byte_ok && asm_low)
        cmd_rdy_q <= 1'b1;
      else if (bus.clr_cmd_rdy || (start_ok && !asm_low))
        cmd_rdy_q <= 1'b0;
    end
  end

`ifdef CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] to_cnt;

  assign timeout = asm_low && (rx_state == RX_IDLE) && !rx_fall &&
                   (to_cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      to_cnt <= '0;
    else if (!asm_low || rx_state != RX_IDLE || timeout)
      to_cnt <= '0;
    else
      to_cnt <= to_cnt + TW'(1);
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_idx_n   = tx_idx;
    tx_shift_n = tx_shift;
    tx_done    = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (bus.send_resp) begin
          tx_state_n = TX_BUSY;
          tx_shift_n = {1'b1, bus.resp, 1'b0};
          tx_cnt_n   = FULL;
          tx_idx_n   = 4'd0;
        end
      end
      TX_BUSY: begin
        if (tx_cnt == '0) begin
          if (tx_idx == 4'd9) begin
            tx_state_n = TX_IDLE;
            tx_shift_n = '1;
            tx_done    = 1'b1;
          end else begin
            tx_shift_n = {1'b1, tx_shift[9:1]};
            tx_idx_n   = tx_idx + 4'd1;
            tx_cnt_n   = FULL;
          end
        end else begin
          tx_cnt_n = tx_cnt - CW'(1);
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state    <= TX_IDLE;
      tx_cnt      <= '0;
      tx_idx      <= 4'd0;
      tx_shift    <= '1;
      resp_sent_q <= 1'b0;
    end else begin
      tx_state    <= tx_state_n;
      tx_cnt      <= tx_cnt_n;
      tx_idx      <= tx_idx_n;
      tx_shift    <= tx_shift_n;
      resp_sent_q <= tx_done;
    end
  end

  // shifter idles all-ones, so bit 0 is the line level
  assign TX            = tx_shift[0];
  assign bus.tx_busy   = (tx_state == TX_BUSY);
  assign bus.resp_sent = resp_sent_q;
  assign bus.cmd       = cmd_q;
  assign bus.cmd_rdy   = cmd_rdy_q;
  assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// tb/tb_uart_cmd_wrapper.sv - directed bench for uart_cmd_wrapper
module tb_uart_cmd_wrapper;
  localparam int B = 108;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  logic tx;
  int   total = 0;
  int   bad = 0;
  int   fe_cnt = 0;
  int   rs_cnt = 0;
  int   fe0, rs0;
  logic [9:0]  frame;
  logic [15:0] exp_cmd;

  uart_cmd_wrapper_if bus();

  uart_cmd_wrapper #(.BAUD_DIV(B)) dut (
    .clk (clk),
    .rst (rst),
    .RX  (rx),
    .TX  (tx),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.frame_err) fe_cnt <= fe_cnt + 1;
    if (bus.resp_sent) rs_cnt <= rs_cnt + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (B) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (B) @(negedge clk);
    end
    rx = stop;
    repeat (B) @(negedge clk);
    rx = 1'b1;
    repeat (B) @(negedge clk);
  endtask

  initial begin
    bus.clr_cmd_rdy = 1'b0;
    bus.resp        = 8'h00;
    bus.send_resp   = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_cmd", bus.cmd, 0);
    check("rst_cmd_rdy", bus.cmd_rdy, 0);
    check("rst_resp_sent", bus.resp_sent, 0);
    check("rst_tx_busy", bus.tx_busy, 0);
    check("rst_frame_err", bus.frame_err, 0);

    send_byte(8'h43, 1'b1);
    check("half_cmd_rdy", bus.cmd_rdy, 0);
    send_byte(8'h16, 1'b1);
    check("cmd_4316", bus.cmd, 16'h4316);
    check("cmd_rdy_set", bus.cmd_rdy, 1);
    bus.clr_cmd_rdy = 1'b1;
    @(negedge clk);
    bus.clr_cmd_rdy = 1'b0;
    check("cmd_rdy_clr", bus.cmd_rdy, 0);
    check("cmd_hold", bus.cmd, 16'h4316);

    bus.resp      = 8'hA5;
    bus.send_resp = 1'b1;
    @(negedge clk);
    bus.send_resp = 1'b0;
    check("tx_start_bit", tx, 0);
    check("tx_busy_rise", bus.tx_busy, 1);
    rs0   = rs_cnt;
    frame = {1'b1, 8'hA5, 1'b0};
    for (int c = 1; c <= 10 * B; c++) begin
      @(negedge clk);
      if (c % B == B / 2) check("tx_bit", tx, frame[c / B]);
      if (c == 3 * B + 5) begin
        bus.resp      = 8'h00;
        bus.send_resp = 1'b1;
      end
      if (c == 3 * B + 6) bus.send_resp = 1'b0;
    end
    check("resp_sent_pulse", bus.resp_sent, 1);
    check("tx_busy_fall", bus.tx_busy, 0);
    check("tx_idle", tx, 1);
    check("no_early_resp_sent", rs_cnt, rs0);
    @(negedge clk);
    check("resp_sent_one_cycle", bus.resp_sent, 0);

    send_byte(8'h06, 1'b1);
    fe0 = fe_cnt;
    send_byte(8'h55, 1'b0);
    check("frame_err_seen", fe_cnt, fe0 + 1);
    check("ferr_no_cmd_rdy", bus.cmd_rdy, 0);
    check("ferr_cmd_kept", bus.cmd, 16'h4316);
    send_byte(8'h06, 1'b1);
    send_byte(8'h55, 1'b1);
    check("cmd_0655", bus.cmd, 16'h0655);
    check("cmd_0655_rdy", bus.cmd_rdy, 1);

    fe0 = fe_cnt;
    rx = 1'b0;
    repeat (20) @(negedge clk);
    rx = 1'b1;
    repeat (200) @(negedge clk);
    check("glitch_cmd_rdy", bus.cmd_rdy, 1);
    check("glitch_no_err", fe_cnt, fe0);

    send_byte(8'h43, 1'b1);
    check("new_hi_clears_rdy", bus.cmd_rdy, 0);
    repeat (25000) @(negedge clk);
    send_byte(8'h06, 1'b1);
    send_byte(8'h55, 1'b1);
`ifdef CMD_TIMEOUT_EN
    exp_cmd = 16'h0655;
`else
    exp_cmd = 16'h4306;
`endif
    check("timeout_cmd", bus.cmd, exp_cmd);

    bus.resp      = 8'hEE;
    bus.send_resp = 1'b1;
    @(negedge clk);
    bus.send_resp = 1'b0;
    repeat (300) @(negedge clk);
    check("tx_busy_before_rst", bus.tx_busy, 1);
    rs0 = rs_cnt;
    rst = 1'b1;
    #1;
    check("rst_mid_tx", tx, 1);
    check("rst_mid_busy", bus.tx_busy, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (1200) @(negedge clk);
    check("rst_no_resp_sent", rs_cnt, rs0);
    check("rst_cmd_clear", bus.cmd, 0);
    check("rst_cmd_rdy_clear", bus.cmd_rdy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
